// File: rtl/lab4_buffer_sched.sv
// LAB4 write-window scheduler: walks {buf,win} through unlocked buffers, locks on trigger, queues events.
// Optional DROP_COUNT_EN builds the saturating dropped-trigger counter (otherwise tied to zero).
module lab4_buffer_sched #(
  parameter  int NBUF          = 4,
  parameter  int WIN_PER_BUF   = 8,
  parameter  int WINDOW_CYCLES = 4,
  localparam int BW            = $clog2(NBUF),
  localparam int WW            = $clog2(WIN_PER_BUF),
  localparam int PW            = $clog2(WINDOW_CYCLES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            trig_i,
  output logic [4:0]      wr_o,
  output logic            wr_en_o,
  output logic [NBUF-1:0] hold_o,
  output logic            evt_valid_o,
  output logic [BW-1:0]   evt_buf_o,
  input  logic            evt_ready_i,
  input  logic            release_i,
  input  logic [BW-1:0]   release_buf_i,
  output logic [15:0]     dropped_count_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FULL = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           buf_q, buf_d, next_buf, cand;
  logic [WW-1:0]           win_q, win_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    pending_q, pending_d;
  logic [NBUF-1:0]         hold_q, hold_d, rel_mask, lock_mask;
  logic [NBUF-1:0][BW-1:0] fifo_q, fifo_d;
  logic [BW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW:0]             cnt_q, cnt_d;
  logic                    trig_acc, rel_vld, last_ph, last_win, buf_end, lock, next_found, pop;

  assign last_ph   = (phase_q == PW'(WINDOW_CYCLES - 1));
  assign last_win  = (win_q == WW'(WIN_PER_BUF - 1));
  assign trig_acc  = trig_i & (state_q == RUN) & ~pending_q;
  assign rel_vld   = release_i & hold_q[release_buf_i];
  assign buf_end   = (state_q == RUN) & enable_i & last_ph & last_win;
  // a trigger landing on the buffer's final cycle still locks that buffer
  assign lock      = buf_end & (pending_q | trig_acc);
  assign rel_mask  = rel_vld ? (NBUF'(1) << release_buf_i) : '0;
  assign lock_mask = lock ? (NBUF'(1) << buf_q) : '0;
  assign hold_d    = (hold_q & ~rel_mask) | lock_mask;
  assign pending_d = (pending_q | trig_acc) & ~lock;
  assign pop       = (cnt_q != '0) & evt_ready_i;

  // Smallest cyclic offset wins; offset NBUF wraps back to the current buffer.
  always_comb begin
    next_found = 1'b0;
    next_buf   = buf_q;
    cand       = buf_q;
    for (int k = NBUF; k >= 1; k--) begin
      cand = buf_q + BW'(k);
      if (!hold_d[cand]) begin
        next_found = 1'b1;
        next_buf   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = IDLE;
               else if (buf_end && !next_found) state_d = FULL;
      FULL:    if (!enable_i) state_d = IDLE;
               else if (rel_vld) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_o = (state_q == RUN);
  end

  always_comb begin
    phase_d = phase_q;
    win_d   = win_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (enable_i) phase_d = '0;
      RUN: if (enable_i) begin
        if (!last_ph) phase_d = phase_q + 1'b1;
        else begin
          phase_d = '0;
          if (!last_win) win_d = win_q + 1'b1;
          else if (next_found) begin
            buf_d = next_buf;
            win_d = '0;
          end
        end
      end
      FULL: if (enable_i && rel_vld) begin
        buf_d   = release_buf_i;
        win_d   = '0;
        phase_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (lock) fifo_d[wr_ptr_q] = buf_q;
    wr_ptr_d = wr_ptr_q + BW'(lock);
    rd_ptr_d = rd_ptr_q + BW'(pop);
    cnt_d    = cnt_q + (BW+1)'(lock) - (BW+1)'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q     <= '0;
      win_q     <= '0;
      phase_q   <= '0;
      pending_q <= 1'b0;
      hold_q    <= '0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      buf_q     <= buf_d;
      win_q     <= win_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_o        = {buf_q, win_q};
  assign hold_o      = hold_q;
  assign evt_valid_o = (cnt_q != '0);
  assign evt_buf_o   = fifo_q[rd_ptr_q];

`ifdef DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (trig_i && !trig_acc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_q <= 16'h0000;
    else       drop_q <= drop_d;
  end

  assign dropped_count_o = drop_q;
`else
  assign dropped_count_o = 16'h0000;
`endif
endmodule

// File: tb/tb_lab4_buffer_sched.sv
// Random-stimulus bench for lab4_buffer_sched against a tick-based buffer model with a per-cycle scoreboard.
module tb_lab4_buffer_sched;
  localparam int NBUF = 4, WPB = 8, WC = 4, TPB = WPB * WC;
`ifdef DROP_COUNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic enable = 1'b0, trig = 1'b0, ready = 1'b0, rel = 1'b0;
  logic [1:0] rel_buf = '0;
  logic [4:0] wr;
  logic wr_en, evt_valid;
  logic [3:0] hold;
  logic [1:0] evt_buf;
  logic [15:0] dropped;

  lab4_buffer_sched dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .trig_i(trig),
    .wr_o(wr), .wr_en_o(wr_en), .hold_o(hold),
    .evt_valid_o(evt_valid), .evt_buf_o(evt_buf), .evt_ready_i(ready),
    .release_i(rel), .release_buf_i(rel_buf), .dropped_count_o(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr; int wr_en; int hold; int ev; int eb; int drop;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Model: state 0 idle / 1 run / 2 full; position within a buffer as a cycle tick.
  int m_st, m_buf, m_tick, m_drop;
  bit m_pend;
  bit [3:0] m_hold;
  int m_fifo[$];

  task automatic m_reset();
    m_st = 0; m_buf = 0; m_tick = 0; m_drop = 0; m_pend = 0; m_hold = '0;
    m_fifo.delete();
  endtask

  function automatic exp_t m_out();
    exp_t e;
    e.wr    = m_buf * WPB + m_tick / WC;
    e.wr_en = (m_st == 1);
    e.hold  = m_hold;
    e.ev    = (m_fifo.size() > 0);
    e.eb    = (m_fifo.size() > 0) ? m_fifo[0] : 0;
    e.drop  = DC ? m_drop : 0;
    return e;
  endfunction

  task automatic m_step(input bit en, input bit tg, input bit rd, input bit rl, input int rb);
    bit acc, relv, found;
    bit [3:0] nh;
    int nb;
    acc  = (m_st == 1) && !m_pend && tg;
    if (tg && !acc && m_drop < 65535) m_drop++;
    relv = rl && m_hold[rb];
    nh   = m_hold;
    if (relv) nh[rb] = 1'b0;
    if (m_fifo.size() > 0 && rd) void'(m_fifo.pop_front());
    case (m_st)
      0: if (en) begin m_st = 1; m_tick = m_tick - m_tick % WC; end
      1: if (!en) begin
           m_st = 0;
           if (acc) m_pend = 1;
         end else if (m_tick == TPB - 1) begin
           if (m_pend || acc) begin
             nh[m_buf] = 1'b1; m_fifo.push_back(m_buf); m_pend = 0;
           end
           found = 0; nb = m_buf;
           for (int off = 1; off <= NBUF && !found; off++)
             if (!nh[(m_buf + off) % NBUF]) begin found = 1; nb = (m_buf + off) % NBUF; end
           if (found) begin m_buf = nb; m_tick = 0; end
           else begin m_st = 2; m_tick = (WPB - 1) * WC; end
         end else begin
           m_tick++;
           if (acc) m_pend = 1;
         end
      default: if (!en) m_st = 0;
               else if (relv) begin m_st = 1; m_buf = rb; m_tick = 0; end
    endcase
    m_hold = nh;
  endtask

  task automatic chk_now(input string tag);
    exp_t e;
    e = m_out();
    chk({tag, "_wr"}, int'(wr), e.wr);
    chk({tag, "_wr_en"}, int'(wr_en), e.wr_en);
    chk({tag, "_hold"}, int'(hold), e.hold);
    chk({tag, "_evt_valid"}, int'(evt_valid), e.ev);
    chk({tag, "_dropped"}, int'(dropped), e.drop);
  endtask

  // Monitor: compare every presented cycle against the scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr", int'(wr), e.wr);
        chk("wr_en", int'(wr_en), e.wr_en);
        chk("hold", int'(hold), e.hold);
        chk("evt_valid", int'(evt_valid), e.ev);
        if (e.ev != 0) chk("evt_buf", int'(evt_buf), e.eb);
        chk("dropped", int'(dropped), e.drop);
      end
    end
  end

  initial begin
    int seg, pt, pr, prd, pe;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk_now("reset");
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c == 3500 || c == 5200) begin
        rst = 1'b1; enable = 0; trig = 0; ready = 0; rel = 0;
        m_reset();
        #1;
        chk_now("async_reset");
        exp_q.push_back(m_out());
        continue;
      end
      rst = 1'b0;
      seg = (c / 1000) % 3;
      case (seg)
        0:       begin pt = 20; pr = 100; prd = 10; pe = 200; end
        1:       begin pt = 10; pr = 400; prd = 4;  pe = 800; end
        default: begin pt = 12; pr = 8;   prd = 2;  pe = 150; end
      endcase
      if ($urandom_range(pe - 1) == 0) enable = ~enable;
      else if (c < 5) enable = 1'b1;
      trig    = ($urandom_range(pt - 1) == 0);
      ready   = ($urandom_range(prd - 1) == 0);
      rel     = ($urandom_range(pr - 1) == 0);
      rel_buf = 2'($urandom_range(3));
      m_step(enable, trig, ready, rel, int'(rel_buf));
      exp_q.push_back(m_out());
    end
    @(negedge clk);
    enable = 0; trig = 0; rel = 0; ready = 0;
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
